// File: rtl/proc12_pkg.sv
// Shared definitions for the 12-bit processor bus: widths, bus state
// encoding and the address-window decode helper.
package proc12_pkg;
   localparam int WORD_W = 12;
   localparam int ADDR_W = 24;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_WAIT = 2'd1,
      BUS_RESP = 2'd2
   } bus_state_e;

   // True when addr lies in the 2**bits word window starting at base.
   function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input int bits);
      return (addr >> bits) == (base >> bits);
   endfunction
endpackage

// File: rtl/word_ram12.sv
// Single-port-write, synchronous-read word RAM for the bus responder.
// Contents are deliberately not reset.
module word_ram12
   import proc12_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [WORD_W-1:0]    wdata_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output logic [WORD_W-1:0]    rdata_o
);
   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // Write port and registered read port; read during write returns old data.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_responder12.sv
// Memory-side target for the 12-bit processor bus. Captures one request,
// waits WAIT_STATES cycles, then returns a one-cycle ready (with err for
// addresses outside the window). All outputs come straight from registers.
module bus_responder12
   import proc12_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h000000,
   parameter int                ADDR_BITS   = 10,
   parameter int                WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              ready_o,
   output logic              err_o,
   output logic              busy_o
);
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   bus_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;

   logic                 hit_s;
   logic                 ram_we_s;
   logic [ADDR_BITS-1:0] ram_raddr_s;
   logic [WORD_W-1:0]    ram_rdata_s;

   assign hit_s = addr_in_window(addr_q, BASE_ADDR, ADDR_BITS);

   word_ram12 #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .waddr_i (addr_q[ADDR_BITS-1:0]),
      .wdata_i (wdata_q),
      .raddr_i (ram_raddr_s),
      .rdata_o (ram_rdata_s)
   );

   // Next-state, request capture, RAM control and response generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      rdata_d     = {WORD_W{1'b0}};
      ram_we_s    = 1'b0;
      // In IDLE the RAM reads the incoming address so that even with zero
      // wait states the word is ready by the time RESP registers it.
      ram_raddr_s = addr_q[ADDR_BITS-1:0];
      // busy drops at the end of the ready cycle.
      if (ready_q) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end

      case (state_q)
         BUS_IDLE: begin
            ram_raddr_s = addr_i[ADDR_BITS-1:0];
            // While busy (the ready cycle) a still-asserted req is the old one.
            if (req_i && !busy_q) begin
               we_d    = we_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               busy_d  = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = BUS_WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = BUS_RESP;
               end
            end else begin
               state_d = BUS_IDLE;
            end
         end
         BUS_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = BUS_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         BUS_RESP: begin
            ready_d  = 1'b1;
            err_d    = !hit_s;
            ram_we_s = we_q && hit_s;
            if (!we_q && hit_s) begin
               rdata_d = ram_rdata_s;
            end else begin
               rdata_d = {WORD_W{1'b0}};
            end
            state_d = BUS_IDLE;
         end
         default: begin
            state_d = BUS_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BUS_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {WORD_W{1'b0}};
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= {WORD_W{1'b0}};
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
      end
   end

   assign rdata_o = rdata_q;
   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign busy_o  = busy_q;
endmodule

// File: tb/tb_bus_responder12.sv
// Randomized scoreboard bench for bus_responder12. Three instances with
// different windows and wait states; a reference memory model per instance.
module tb_bus_responder12;
   logic        clk = 1'b0;
   logic        rst;
   logic        req   [3];
   logic        we    [3];
   logic [23:0] addr  [3];
   logic [11:0] wdata [3];
   logic [11:0] rdata [3];
   logic        ready [3];
   logic        err   [3];
   logic        busy  [3];

   int nchecks = 0;
   int nerrors = 0;
   int cyc = 0;

   typedef struct {
      int          d;
      bit          rd;
      bit          err;
      logic [11:0] data;
   } exp_t;

   exp_t        sb [$];
   logic [11:0] mem_m [3][1024];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bus_responder12 #(.BASE_ADDR(24'h000000), .ADDR_BITS(10), .WAIT_STATES(1)) dut0 (
      .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0]),
      .busy_o(busy[0]));
   bus_responder12 #(.BASE_ADDR(24'h000000), .ADDR_BITS(10), .WAIT_STATES(0)) dut1 (
      .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1]),
      .busy_o(busy[1]));
   bus_responder12 #(.BASE_ADDR(24'h001000), .ADDR_BITS(8), .WAIT_STATES(3)) dut2 (
      .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
      .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ready_o(ready[2]), .err_o(err[2]),
      .busy_o(busy[2]));

   function automatic int ab_of(input int d);
      return (d == 2) ? 8 : 10;
   endfunction

   function automatic int base_of(input int d);
      return (d == 2) ? 32'h1000 : 0;
   endfunction

   function automatic int ws_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   function automatic bit in_win(input int d, input logic [23:0] a);
      int size;
      size = 1 << ab_of(d);
      return (int'(a) / size) == (base_of(d) / size);
   endfunction

   function automatic int offset_of(input int d, input logic [23:0] a);
      return int'(a) % (1 << ab_of(d));
   endfunction

   function automatic logic [23:0] rand_addr(input int d);
      int k;
      k = int'($urandom_range(0, 4));
      if (k == 0) begin
         return 24'(base_of(d) + (1 << ab_of(d)) * int'($urandom_range(1, 100))
                    + int'($urandom_range(0, 31)));
      end else if (k == 1) begin
         return 24'h800000 | 24'(base_of(d) + int'($urandom_range(0, 31)));
      end else begin
         return 24'(base_of(d) + int'($urandom_range(0, 31)));
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One complete transaction on instance d; expectation pushed at issue time.
   task automatic txn(input int d, input bit w, input logic [23:0] a, input logic [11:0] wd);
      exp_t e;
      int   lat;
      bit   seen;
      e.d    = d;
      e.rd   = !w;
      e.err  = !in_win(d, a);
      e.data = (!w && in_win(d, a)) ? mem_m[d][offset_of(d, a)] : 12'h000;
      if (w && in_win(d, a)) mem_m[d][offset_of(d, a)] = wd;
      sb.push_back(e);
      @(posedge clk); #1;
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      @(posedge clk); #1;
      // Held inputs change after capture; they must have no effect.
      we[d] = 1'($urandom); addr[d] = 24'($urandom); wdata[d] = 12'($urandom);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         if (ready[d]) begin
            seen = 1'b1;
         end else begin
            @(posedge clk);
            lat++;
         end
      end
      req[d] = 1'b0;
      chk("ready_seen", 32'(seen), 32'd1);
      chk("latency", lat, ws_of(d) + 1);
   endtask

   // Scoreboard monitor: pops an expectation on every ready strobe.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         for (int d = 0; d < 3; d++) begin
            if (ready[d]) begin
               if (sb.size() == 0) begin
                  chk("spurious_ready", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("resp_instance", d, e.d);
                  chk("resp_err", 32'(err[d]), 32'(e.err));
                  chk("resp_busy", 32'(busy[d]), 32'd1);
                  if (e.rd) chk("resp_rdata", 32'(rdata[d]), 32'(e.data));
               end
            end else begin
               chk("idle_outputs", {19'd0, err[d], rdata[d]}, 32'd0);
            end
         end
      end
   end

   initial begin
      int          n;
      int          last;
      int          to;
      exp_t        e;
      logic [11:0] wv;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; addr[d] = 24'h0; wdata[d] = 12'h0;
      end
      // Reset state.
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_ready", 32'(ready[d]), 32'd0);
         chk("rst_err", 32'(err[d]), 32'd0);
         chk("rst_busy", 32'(busy[d]), 32'd0);
         chk("rst_rdata", 32'(rdata[d]), 32'd0);
      end
      rst = 1'b1;

      // Give every instance known contents in offsets 0..31.
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 32; i++) begin
            txn(d, 1'b1, 24'(base_of(d) + i), 12'($urandom));
         end
      end

      // Write then read back.
      txn(0, 1'b1, 24'h000010, 12'hA5C);
      txn(0, 1'b0, 24'h000010, 12'h000);

      // Out-of-window read and write; RAM[0] must be unaffected (no wrap).
      txn(0, 1'b0, 24'h000000, 12'h000);
      txn(0, 1'b0, 24'h000400, 12'h000);
      txn(0, 1'b1, 24'h000400, 12'hFFF);
      txn(0, 1'b0, 24'h000000, 12'h000);

      // Zero and three wait states.
      txn(1, 1'b1, 24'h000005, 12'h3C3);
      txn(1, 1'b0, 24'h000005, 12'h000);
      txn(2, 1'b1, 24'h001007, 12'h5A5);
      txn(2, 1'b0, 24'h001007, 12'h000);
      txn(2, 1'b0, 24'h000007, 12'h000);

      // req held high across three writes.
      for (int i = 1; i <= 3; i++) begin
         e.d = 0; e.rd = 1'b0; e.err = 1'b0; e.data = 12'h000;
         mem_m[0][i] = 12'(i);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 24'h000001; wdata[0] = 12'h001;
      n = 0; last = -100; to = 0;
      while (n < 3 && to < 200) begin
         @(negedge clk);
         to++;
         if (ready[0]) begin
            n++;
            if (n > 1) chk("b2b_gap", 32'((cyc - last) >= 2), 32'd1);
            last = cyc;
            if (n < 3) begin
               addr[0] = 24'(n + 1); wdata[0] = 12'(n + 1);
            end else begin
               req[0] = 1'b0;
            end
         end
      end
      req[0] = 1'b0;
      chk("b2b_pulses", n, 3);
      repeat (6) @(posedge clk);
      for (int i = 1; i <= 3; i++) txn(0, 1'b0, 24'(i), 12'h000);

      // Reset while a write sits in WAIT: no ready, no write.
      txn(0, 1'b1, 24'h000020, 12'h135);
      @(posedge clk); #1;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 24'h000020; wdata[0] = 12'h777;
      @(posedge clk); #1;
      chk("busy_in_wait", 32'(busy[0]), 32'd1);
      rst = 1'b0;
      req[0] = 1'b0;
      #1;
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_ready", 32'(ready[0]), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      txn(0, 1'b0, 24'h000020, 12'h000);

      // Randomized traffic on all instances.
      for (int k = 0; k < 180; k++) begin
         int d;
         d  = int'($urandom_range(0, 2));
         wv = 12'($urandom);
         txn(d, 1'($urandom), rand_addr(d), wv);
      end

      repeat (8) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
